muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer for the HI/LO multiply/divide resource in the EX stage. Accepts the one-hot mult/multu/div/divu/mthi/mtlo command from the decoded exe_ctrl bits and runs a fixed-latency multiply or a 32-step restoring divide. It owns the HI/LO registers. It stalls the pipeline when a new HI/LO command, or an mfhi/mflo read, arrives while an operation is in flight.

Parameters:
MUL_CYCLES, 3, busy cycles for mult/multu (legal range 1..15)
DIV_STEPS, 32, restoring-divide iterations (fixed at 32 for 32-bit operands)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
op_i  input  6  {mult,multu,div,divu,mthi,mtlo}; one-hot; if several bits are set, leftmost wins
src_a_i  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
src_b_i  input  32  rt operand (divisor / multiplier)
rd_hi_i  input  1  mfhi in stage needing HI
rd_lo_i  input  1  mflo in stage needing LO
cancel_i  input  1  exception flush; aborts the in-flight or presented op
hi_o  output  32  HI register
lo_o  output  32  LO register
busy_o  output  1  operation in flight
stall_o  output  1  combinational pipeline stall request
done_o  output  1  one-cycle pulse on the cycle HI/LO were just updated by mult/div
dz_o  output  1  one-cycle pulse: div/divu with src_b_i == 0

Behaviour:
- Reset (async, resetn=0): state IDLE; hi_o=lo_o=0; busy_o=done_o=dz_o=0; counters cleared. Reset mid-operation discards the operation.
- States: IDLE, MUL, DIV, FIX.
- Accept: at a rising edge with state IDLE, op_i!=0 and cancel_i=0. Operands are latched at this edge.
- mthi/mtlo: HI or LO is written with src_a_i at the accept edge. State stays IDLE. No busy, no done.
- mult/multu: 64-bit signed/unsigned product of the latched operands. Go to MUL and load the counter with MUL_CYCLES-1. busy_o is high for exactly MUL_CYCLES cycles. At the final edge: {HI,LO}=product, done_o=1 for the next cycle, return to IDLE.
- div/divu, divisor != 0: signed ops divide magnitudes. Go to DIV. 32 iteration edges, one quotient bit per edge (MSB first). Then FIX (1 cycle) applies signs: quotient negated if signs differ; remainder takes the dividend's sign. At the FIX edge LO=quotient, HI=remainder, done_o pulses. busy_o is high for 33 cycles.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- div/divu with divisor 0: no busy. HI/LO unchanged. dz_o and done_o pulse in the cycle after the accept edge.
- stall_o = busy_o & (op_i!=0 | rd_hi_i | rd_lo_i). It drops in the cycle done_o is high, and a read in that cycle sees the new HI/LO. A held op is accepted at the edge ending that cycle.
- No stall in IDLE. A read in the same cycle as an mthi/mtlo accept returns the old value; the decoder/forwarding logic handles this.
- cancel_i=1 in IDLE: the presented op is dropped.
- cancel_i=1 while busy: return to IDLE at the next edge; HI/LO unchanged; no done_o. cancel_i has priority over completion on the same edge.
- Counters wrap only via explicit reload; never free-running.

Optional Feature:
MULDIV_DIV_EARLY_OUT_EN: when defined, a div/divu (nonzero divisor) with |dividend| < |divisor| skips DIV. It goes directly to FIX: LO=0, HI=dividend (original sign), done_o in the cycle after FIX, busy_o high for 1 cycle. When undefined, every nonzero-divisor divide takes the full 33 busy cycles.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=7 -> after 3 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, done_o one pulse; multu a=0xFFFFFFFF, b=2 -> HI=1, LO=0xFFFFFFFE.
- divu 100/7 -> busy_o exactly 33 cycles, then LO=14, HI=2; div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div with b=0 after HI=0x11, LO=0x22 via mthi/mtlo -> dz_o pulse, no busy, HI=0x11, LO=0x22 unchanged.
- rd_hi_i held and a second mult presented during divu -> stall_o high every busy cycle, low in done cycle; the mult is accepted at that edge with the new HI visible to the read.
- cancel_i at busy cycle 10 of div -> IDLE next cycle, no done_o, HI/LO equal pre-op values; resetn low mid-MUL -> all outputs 0 immediately.
- With MULDIV_DIV_EARLY_OUT_EN: divu 5/9 -> busy 1 cycle, LO=0, HI=5; without it -> 33 cycles, same result.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer for the EX stage.
// Owns HI/LO, runs a fixed-latency multiply or a 32-step restoring divide,
// and requests a pipeline stall while an operation is in flight.
// Optional build macro: MULDIV_DIV_EARLY_OUT_EN (divides with |a| < |b|
// bypass the iteration loop and go straight to sign fix-up).
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_STEPS  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        rd_hi_i,
  input  logic        rd_lo_i,
  input  logic        cancel_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        dz_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  localparam logic [4:0] CNT_MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] CNT_DIV_LOAD = 5'(DIV_STEPS - 1);

  // Magnitude of a possibly-signed operand (most negative value maps to 2^31).
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    logic [31:0] res;
    if (is_signed && v[31]) begin
      res = ~v + 32'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Two's-complement negate under a condition (sign fix-up of divide results).
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic do_neg);
    logic [31:0] res;
    if (do_neg) begin
      res = ~v + 32'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic        r_mul_signed;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_dz;

  logic        w_any_op;
  logic        w_sel_mult;
  logic        w_sel_multu;
  logic        w_sel_div;
  logic        w_sel_divu;
  logic        w_sel_mthi;
  logic        w_sel_mtlo;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_op_signed;
  logic        w_b_zero;
  logic        w_accept;
  logic        w_div_start;
  logic        w_dz_accept;
  logic        w_early;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_fin_mul;
  logic        w_fin_div;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [31:0] w_rem_step;
  logic [31:0] w_quot_step;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // Priority decode of the command: leftmost set bit wins.
  always_comb begin
    w_any_op    = 1'b1;
    w_sel_mult  = 1'b0;
    w_sel_multu = 1'b0;
    w_sel_div   = 1'b0;
    w_sel_divu  = 1'b0;
    w_sel_mthi  = 1'b0;
    w_sel_mtlo  = 1'b0;
    casez (op_i)
      6'b1?????: w_sel_mult  = 1'b1;
      6'b01????: w_sel_multu = 1'b1;
      6'b001???: w_sel_div   = 1'b1;
      6'b0001??: w_sel_divu  = 1'b1;
      6'b00001?: w_sel_mthi  = 1'b1;
      6'b000001: w_sel_mtlo  = 1'b1;
      default:   w_any_op    = 1'b0;
    endcase
  end

  // Accept qualification, operand magnitudes and the early-out decision.
  always_comb begin
    w_is_mul    = w_sel_mult | w_sel_multu;
    w_is_div    = w_sel_div | w_sel_divu;
    w_op_signed = w_sel_mult | w_sel_div;
    w_b_zero    = (src_b_i == 32'd0);
    w_accept    = (r_state == ST_IDLE) && w_any_op && !cancel_i;
    w_div_start = w_accept && w_is_div && !w_b_zero;
    w_dz_accept = w_accept && w_is_div && w_b_zero;
    w_abs_a     = abs32(src_a_i, w_op_signed);
    w_abs_b     = abs32(src_b_i, w_op_signed);
`ifdef MULDIV_DIV_EARLY_OUT_EN
    w_early     = (w_abs_a < w_abs_b);
`else
    w_early     = 1'b0;
`endif
  end

  // Product, one restoring-divide step and the final sign fix-up.
  always_comb begin
    w_ext_a  = {{32{r_mul_signed & r_mul_a[31]}}, r_mul_a};
    w_ext_b  = {{32{r_mul_signed & r_mul_b[31]}}, r_mul_b};
    w_prod   = w_ext_a * w_ext_b;
    w_rem_sh = {r_rem, r_quot[31]};
    w_diff   = w_rem_sh - {1'b0, r_div};
    if (!w_diff[32]) begin
      w_rem_step  = w_diff[31:0];
      w_quot_step = {r_quot[30:0], 1'b1};
    end else begin
      w_rem_step  = w_rem_sh[31:0];
      w_quot_step = {r_quot[30:0], 1'b0};
    end
    w_q_fix = neg_if(r_quot, r_neg_q);
    w_r_fix = neg_if(r_rem, r_neg_r);
  end

  // Next-state logic; cancel beats completion.
  always_comb begin
    w_next_state = r_state;
    w_fin_mul    = 1'b0;
    w_fin_div    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_next_state = ST_MUL;
        end else if (w_div_start) begin
          w_next_state = w_early ? ST_FIX : ST_DIV;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cancel_i) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == 5'd0) begin
          w_next_state = ST_IDLE;
          w_fin_mul    = 1'b1;
        end else begin
          w_next_state = ST_MUL;
        end
      end
      ST_DIV: begin
        if (cancel_i) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == 5'd0) begin
          w_next_state = ST_FIX;
        end else begin
          w_next_state = ST_DIV;
        end
      end
      ST_FIX: begin
        w_next_state = ST_IDLE;
        if (cancel_i) begin
          w_fin_div = 1'b0;
        end else begin
          w_fin_div = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Cycle/step counter: loaded on accept, counts down only while in MUL/DIV.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 5'd0;
    end else if (w_accept && w_is_mul) begin
      r_cnt <= CNT_MUL_LOAD;
    end else if (w_div_start) begin
      r_cnt <= CNT_DIV_LOAD;
    end else if (cancel_i && (r_state != ST_IDLE)) begin
      r_cnt <= 5'd0;
    end else if (((r_state == ST_MUL) || (r_state == ST_DIV)) && (r_cnt != 5'd0)) begin
      r_cnt <= r_cnt - 5'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Operand latches and the divider shift registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mul_a      <= 32'd0;
      r_mul_b      <= 32'd0;
      r_mul_signed <= 1'b0;
      r_quot       <= 32'd0;
      r_rem        <= 32'd0;
      r_div        <= 32'd0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_mul_a      <= src_a_i;
      r_mul_b      <= src_b_i;
      r_mul_signed <= w_sel_mult;
    end else if (w_div_start) begin
      r_div   <= w_abs_b;
      r_neg_q <= w_sel_div & (src_a_i[31] ^ src_b_i[31]);
      r_neg_r <= w_sel_div & src_a_i[31];
      if (w_early) begin
        // Quotient is zero and the remainder is the dividend itself.
        r_quot <= 32'd0;
        r_rem  <= w_abs_a;
      end else begin
        r_quot <= w_abs_a;
        r_rem  <= 32'd0;
      end
    end else if ((r_state == ST_DIV) && !cancel_i) begin
      r_quot <= w_quot_step;
      r_rem  <= w_rem_step;
    end else begin
      r_quot <= r_quot;
      r_rem  <= r_rem;
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_accept && w_sel_mthi) begin
      r_hi <= src_a_i;
    end else if (w_accept && w_sel_mtlo) begin
      r_lo <= src_a_i;
    end else if (w_fin_mul) begin
      r_hi <= w_prod[63:32];
      r_lo <= w_prod[31:0];
    end else if (w_fin_div) begin
      r_hi <= w_r_fix;
      r_lo <= w_q_fix;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  // Registered status: busy, completion pulse and divide-by-zero pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= w_fin_mul | w_fin_div | w_dz_accept;
      r_dz   <= w_dz_accept;
    end
  end

  assign hi_o    = r_hi;
  assign lo_o    = r_lo;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign dz_o    = r_dz;
  assign stall_o = r_busy & (w_any_op | rd_hi_i | rd_lo_i);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

  localparam logic [5:0] OP_MULT  = 6'b100000;
  localparam logic [5:0] OP_MULTU = 6'b010000;
  localparam logic [5:0] OP_DIV   = 6'b001000;
  localparam logic [5:0] OP_DIVU  = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000010;
  localparam logic [5:0] OP_MTLO  = 6'b000001;

`ifdef MULDIV_DIV_EARLY_OUT_EN
  localparam int EARLY_BUSY = 1;
`else
  localparam int EARLY_BUSY = 33;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        rd_hi_i;
  logic        rd_lo_i;
  logic        cancel_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic        dz_o;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.MUL_CYCLES(3), .DIV_STEPS(32)) dut (
    .clk(clk), .resetn(resetn), .op_i(op_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
    .rd_hi_i(rd_hi_i), .rd_lo_i(rd_lo_i), .cancel_i(cancel_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .stall_o(stall_o),
    .done_o(done_o), .dz_o(dz_o)
  );

  always #5 clk = ~clk;

  // Present a command at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; src_a_i = a; src_b_i = b;
    @(negedge clk);
    op_i = 6'd0;
  endtask

  // Count busy cycles from the current negedge; returns at the first idle negedge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; op_i = 6'd0; src_a_i = 32'd0; src_b_i = 32'd0;
    rd_hi_i = 1'b0; rd_lo_i = 1'b0; cancel_i = 1'b0;
    #2;
    checks++;
    if ({hi_o, lo_o, busy_o, done_o, dz_o, stall_o} !== 68'd0) begin
      errors++; $display("FAIL reset got hi=%h lo=%h busy=%b done=%b dz=%b exp all 0", hi_o, lo_o, busy_o, done_o, dz_o);
    end
    @(negedge clk); resetn = 1'b1; @(negedge clk);
  endtask

  task automatic test_mult();
    int n;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL mult_busy got %0d exp 3", n); end
    checks++;
    if ({done_o, hi_o, lo_o} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      errors++; $display("FAIL mult_result got done=%b hi=%h lo=%h exp 1 ffffffff ffffffeb", done_o, hi_o, lo_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", done_o); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    checks++;
    if ({hi_o, lo_o} !== {32'd1, 32'hFFFF_FFFE}) begin
      errors++; $display("FAIL multu_result got hi=%h lo=%h exp 00000001 fffffffe", hi_o, lo_o);
    end
    // mult and divu both set: mult wins
    issue(6'b100100, 32'd2, 32'd3);
    wait_idle(n);
    checks++;
    if ({n, hi_o, lo_o} !== {32'd3, 32'd0, 32'd6}) begin
      errors++; $display("FAIL priority got n=%0d hi=%h lo=%h exp 3 0 6", n, hi_o, lo_o);
    end
  endtask

  task automatic test_div();
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL divu_busy got %0d exp 33", n); end
    checks++;
    if ({done_o, hi_o, lo_o} !== {1'b1, 32'd2, 32'd14}) begin
      errors++; $display("FAIL divu_result got done=%b hi=%h lo=%h exp 1 2 14", done_o, hi_o, lo_o);
    end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++;
    if ({hi_o, lo_o} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL div_neg got hi=%h lo=%h exp ffffffff fffffffd", hi_o, lo_o);
    end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++;
    if ({hi_o, lo_o} !== {32'd0, 32'h8000_0000}) begin
      errors++; $display("FAIL div_overflow got hi=%h lo=%h exp 0 80000000", hi_o, lo_o);
    end
  endtask

  task automatic test_div_zero();
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    checks++;
    if ({busy_o, hi_o, lo_o} !== {1'b0, 32'h11, 32'h22}) begin
      errors++; $display("FAIL mthi_mtlo got busy=%b hi=%h lo=%h exp 0 11 22", busy_o, hi_o, lo_o);
    end
    issue(OP_DIV, 32'd5, 32'd0);
    checks++;
    if ({dz_o, done_o, busy_o, hi_o, lo_o} !== {3'b110, 32'h11, 32'h22}) begin
      errors++; $display("FAIL div_zero got dz=%b done=%b busy=%b hi=%h lo=%h exp 1 1 0 11 22", dz_o, done_o, busy_o, hi_o, lo_o);
    end
    @(negedge clk);
    checks++;
    if ({dz_o, done_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL div_zero_pulse got dz=%b done=%b busy=%b exp 000", dz_o, done_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    op_i = OP_DIVU; src_a_i = 32'd100; src_b_i = 32'd7;
    @(negedge clk);
    op_i = OP_MULT; src_a_i = 32'd3; src_b_i = 32'd5; rd_hi_i = 1'b1;
    n = 0; bad = 0;
    while (busy_o && n < 200) begin
      if (stall_o !== 1'b1) bad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if ({n, bad} !== {32'd33, 32'd0}) begin
      errors++; $display("FAIL b2b_stall got busy=%0d stall_low=%0d exp 33 0", n, bad);
    end
    checks++;
    if ({stall_o, done_o, hi_o, lo_o} !== {2'b01, 32'd2, 32'd14}) begin
      errors++; $display("FAIL b2b_done got stall=%b done=%b hi=%h lo=%h exp 0 1 2 14", stall_o, done_o, hi_o, lo_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy_o); end
    op_i = 6'd0; rd_hi_i = 1'b0;
    wait_idle(n);
    checks++;
    if ({n, hi_o, lo_o} !== {32'd3, 32'd0, 32'd15}) begin
      errors++; $display("FAIL b2b_mult got n=%0d hi=%h lo=%h exp 3 0 15", n, hi_o, lo_o);
    end
  endtask

  task automatic test_cancel();
    int pulses;
    issue(OP_MTHI, 32'hAAAA, 32'd0);
    issue(OP_MTLO, 32'hBBBB, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++; $display("FAIL cancel_busy got busy=%b done=%b exp 00", busy_o, done_o);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    checks++;
    if ({pulses, hi_o, lo_o} !== {32'd0, 32'hAAAA, 32'hBBBB}) begin
      errors++; $display("FAIL cancel_hilo got pulses=%0d hi=%h lo=%h exp 0 aaaa bbbb", pulses, hi_o, lo_o);
    end
    cancel_i = 1'b1;
    issue(OP_MTHI, 32'h1234, 32'd0);
    cancel_i = 1'b0;
    checks++;
    if (hi_o !== 32'hAAAA) begin errors++; $display("FAIL cancel_idle got %h exp aaaa", hi_o); end
    issue(OP_MULT, 32'd2, 32'd3);
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, dz_o, hi_o, lo_o} !== 67'd0) begin
      errors++; $display("FAIL reset_mid_mul got busy=%b hi=%h lo=%h exp 0 0 0", busy_o, hi_o, lo_o);
    end
    @(negedge clk); resetn = 1'b1; @(negedge clk);
    checks++;
    if ({busy_o, done_o, hi_o, lo_o} !== 66'd0) begin
      errors++; $display("FAIL reset_release got busy=%b done=%b hi=%h lo=%h exp 0", busy_o, done_o, hi_o, lo_o);
    end
  endtask

  task automatic test_early_out();
    int n;
    issue(OP_DIVU, 32'd5, 32'd9);
    wait_idle(n);
    checks++;
    if ({n, hi_o, lo_o} !== {EARLY_BUSY, 32'd5, 32'd0}) begin
      errors++; $display("FAIL early_divu got n=%0d hi=%h lo=%h exp %0d 5 0", n, hi_o, lo_o, EARLY_BUSY);
    end
    issue(OP_DIV, 32'hFFFF_FFFB, 32'd9);
    wait_idle(n);
    checks++;
    if ({n, done_o, hi_o, lo_o} !== {EARLY_BUSY, 1'b1, 32'hFFFF_FFFB, 32'd0}) begin
      errors++; $display("FAIL early_div got n=%0d done=%b hi=%h lo=%h exp %0d 1 fffffffb 0", n, done_o, hi_o, lo_o, EARLY_BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_cancel();
    test_early_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
